// File: rtl/icache_line_fill_if.sv
// Request/fill/bus signal bundle for the ICache line-fill engine.
// master = fill engine view, slave = ICache plus memory-bus view.
interface icache_line_fill_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int BEATS  = 4
);
  logic                    req_valid_i;
  logic [ADDR_W-1:0]       req_addr_i;
  logic                    fill_ready_o;
  logic [WORD_W*BEATS-1:0] fill_data_o;
  logic                    fill_err_o;
  logic                    busy_o;
  logic                    bus_req_o;
  logic [ADDR_W-1:0]       bus_addr_o;
  logic                    bus_gnt_i;
  logic                    bus_rvalid_i;
  logic [WORD_W-1:0]       bus_rdata_i;
  logic                    bus_err_i;

  modport master (
    input  req_valid_i, req_addr_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output fill_ready_o, fill_data_o, fill_err_o, busy_o, bus_req_o, bus_addr_o
  );

  modport slave (
    output req_valid_i, req_addr_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  fill_ready_o, fill_data_o, fill_err_o, busy_o, bus_req_o, bus_addr_o
  );
endinterface

// File: rtl/icache_line_fill.sv
// ICache refill engine: fetches BEATS words over a single-outstanding bus into one line.
// Define ICACHE_FILL_CRIT_FIRST_EN for critical-word-first beat ordering.
module icache_line_fill #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int BEATS  = 4
) (
  input logic               clk,
  input logic               rst,
  icache_line_fill_if.master io_if
);
  localparam int LINE_W = WORD_W * BEATS;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(BEATS * 4);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * 4 - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [BEAT_W-1:0] r_beat;
  logic              r_err;
  logic [LINE_W-1:0] r_data;
  logic [BEAT_W-1:0] w_slot;

`ifdef ICACHE_FILL_CRIT_FIRST_EN
  logic [BEAT_W-1:0] r_w0;

  // Slot index wraps naturally because BEATS is a power of two.
  assign w_slot = r_beat + r_w0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_w0 <= '0;
    else if (r_state == S_IDLE && io_if.req_valid_i)
      r_w0 <= io_if.req_addr_i[OFF_W-1:2];
  end
`else
  assign w_slot = r_beat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_if.req_valid_i) begin
            r_base  <= io_if.req_addr_i & LINE_MASK;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (io_if.bus_gnt_i)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (io_if.bus_rvalid_i) begin
            // Error beats still store their data; the line always completes.
            r_data[w_slot*WORD_W +: WORD_W] <= io_if.bus_rdata_i;
            r_err <= r_err | io_if.bus_err_i;
            if (r_beat == BEAT_W'(BEATS - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_beat  <= r_beat + BEAT_W'(1);
              r_state <= S_REQ;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request/address decode straight from state so an async reset drops them at once.
  assign io_if.bus_req_o    = (r_state == S_REQ);
  assign io_if.bus_addr_o   = r_base + (ADDR_W'(w_slot) << 2);
  assign io_if.busy_o       = (r_state != S_IDLE);
  assign io_if.fill_ready_o = (r_state == S_DONE);
  assign io_if.fill_err_o   = (r_state == S_DONE) & r_err;
  assign io_if.fill_data_o  = r_data;
endmodule

// File: tb/tb_icache_line_fill.sv
// Randomized self-checking bench for icache_line_fill against a line-level reference model.
module tb_icache_line_fill;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int NB = 4;
  localparam int LW = WW * NB;
  typedef logic [LW-1:0] val_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ready_cnt = 0;
  logic [31:0] salt = '0;

  icache_line_fill_if #(.ADDR_W(AW), .WORD_W(WW), .BEATS(NB)) bif();

  icache_line_fill #(.ADDR_W(AW), .WORD_W(WW), .BEATS(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_if (bif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bif.fill_ready_o === 1'b1) ready_cnt++;

  task automatic chk(input string tag, input val_t got, input val_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: plain word pattern, optionally salted per line for random runs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1111_0000 + {30'd0, a[3:2]} + salt * (a >> 4);
  endfunction

  function automatic int first_word(input logic [31:0] a);
`ifdef ICACHE_FILL_CRIT_FIRST_EN
    return int'(a[3:2]);
`else
    return 0;
`endif
  endfunction

  task automatic bus_quiet();
    bif.req_valid_i  = 1'b0;
    bif.bus_gnt_i    = 1'b0;
    bif.bus_rvalid_i = 1'b0;
    bif.bus_rdata_i  = '0;
    bif.bus_err_i    = 1'b0;
  endtask

  task automatic abort_fill(input int rc0);
    rst = 1'b1;
    #1;
    chk("abort_req_lo",  val_t'(bif.bus_req_o),    val_t'(0));
    chk("abort_busy",    val_t'(bif.busy_o),       val_t'(0));
    chk("abort_data",    val_t'(bif.fill_data_o),  val_t'(0));
    @(negedge clk);
    rst = 1'b0;
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = $urandom;
    bif.bus_err_i    = 1'b1;
    @(negedge clk);
    bus_quiet();
    chk("late_rv_busy",  val_t'(bif.busy_o),       val_t'(0));
    chk("late_rv_ready", val_t'(bif.fill_ready_o), val_t'(0));
    chk("late_rv_data",  val_t'(bif.fill_data_o),  val_t'(0));
    repeat (3) @(negedge clk);
    chk("abort_no_pulse", val_t'(ready_cnt - rc0), val_t'(0));
    chk("abort_idle_req", val_t'(bif.bus_req_o),   val_t'(0));
  endtask

  // One line fill: gw/rw are per-beat grant/rvalid stall cycles, emask marks error beats.
  task automatic do_fill(input logic [31:0] addr, input logic [NB-1:0][3:0] gw,
                         input logic [NB-1:0][3:0] rw, input logic [NB-1:0] emask,
                         input bit noise, input int abort_beat, input bit abort_in_req);
    logic [31:0] base;
    logic [31:0] ea;
    val_t        exp_line;
    int          w0, rc0;
    base     = addr & ~32'(NB * 4 - 1);
    w0       = first_word(addr);
    exp_line = '0;
    for (int k = 0; k < NB; k++) exp_line[WW*k +: WW] = mem_word(base + 32'(4 * k));
    rc0 = ready_cnt;

    bif.req_valid_i = 1'b1;
    bif.req_addr_i  = addr;
    @(negedge clk);
    bif.req_valid_i = 1'b0;
    bif.req_addr_i  = $urandom;

    for (int k = 0; k < NB; k++) begin
      ea = base + 32'(4 * ((w0 + k) % NB));
      if (k == abort_beat && abort_in_req) begin
        abort_fill(rc0);
        return;
      end
      for (int i = 0; i <= int'(gw[k]); i++) begin
        chk("bus_req_hi",  val_t'(bif.bus_req_o),  val_t'(1));
        chk("bus_addr",    val_t'(bif.bus_addr_o), val_t'(ea));
        chk("busy_in_req", val_t'(bif.busy_o),     val_t'(1));
        if (i == int'(gw[k])) bif.bus_gnt_i = 1'b1;
        if (noise) begin
          // Read data during REQ (including the grant cycle) must be ignored.
          bif.bus_rvalid_i = 1'b1;
          bif.bus_rdata_i  = 32'hDEAD_BEEF;
          bif.bus_err_i    = 1'b1;
        end
        @(negedge clk);
        bus_quiet();
      end
      chk("bus_req_lo", val_t'(bif.bus_req_o), val_t'(0));
      if (k == abort_beat) begin
        abort_fill(rc0);
        return;
      end
      for (int i = 0; i <= int'(rw[k]); i++) begin
        if (i == int'(rw[k])) begin
          bif.bus_rvalid_i = 1'b1;
          bif.bus_rdata_i  = mem_word(ea);
          bif.bus_err_i    = emask[k];
        end else if (noise) begin
          bif.bus_gnt_i   = 1'b1;
          bif.req_valid_i = 1'b1;
          bif.req_addr_i  = 32'h0000_0040;
        end
        @(negedge clk);
        bus_quiet();
      end
    end

    chk("fill_ready", val_t'(bif.fill_ready_o), val_t'(1));
    chk("fill_err",   val_t'(bif.fill_err_o),   val_t'(|emask));
    chk("fill_data",  bif.fill_data_o,          exp_line);
    chk("done_busy",  val_t'(bif.busy_o),       val_t'(1));
    if (noise) begin
      bif.req_valid_i = 1'b1;
      bif.req_addr_i  = 32'h0000_0040;
    end
    @(negedge clk);
    bus_quiet();
    chk("ready_drop", val_t'(bif.fill_ready_o), val_t'(0));
    chk("err_drop",   val_t'(bif.fill_err_o),   val_t'(0));
    chk("idle_busy",  val_t'(bif.busy_o),       val_t'(0));
    chk("data_hold",  bif.fill_data_o,          exp_line);
    @(negedge clk);
    chk("one_pulse",  val_t'(ready_cnt - rc0),  val_t'(1));
  endtask

  initial begin
    logic [NB-1:0][3:0] gw, rw;
    logic [NB-1:0]      em;
    rst = 1'b1;
    bif.req_addr_i = '0;
    bus_quiet();
    repeat (3) @(negedge clk);
    chk("rst_ready", val_t'(bif.fill_ready_o), val_t'(0));
    chk("rst_data",  bif.fill_data_o,          val_t'(0));
    chk("rst_err",   val_t'(bif.fill_err_o),   val_t'(0));
    chk("rst_busy",  val_t'(bif.busy_o),       val_t'(0));
    chk("rst_req",   val_t'(bif.bus_req_o),    val_t'(0));
    chk("rst_addr",  val_t'(bif.bus_addr_o),   val_t'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with the plain memory image.
    do_fill(32'h0000_0021, '0, '0, '0, 1'b0, -1, 1'b0);
    chk("plan_line", bif.fill_data_o, 128'h1111_0003_1111_0002_1111_0001_1111_0000);
    do_fill(32'h0000_0021, {NB{4'd3}}, {NB{4'd2}}, '0, 1'b0, -1, 1'b0);
    chk("plan_line_ws", bif.fill_data_o, 128'h1111_0003_1111_0002_1111_0001_1111_0000);
    do_fill(32'h0000_0021, '0, '0, 4'b0100, 1'b0, -1, 1'b0);
    do_fill(32'h0000_0024, '0, {NB{4'd1}}, '0, 1'b0, -1, 1'b0);
    do_fill(32'h0000_0000, '0, {NB{4'd2}}, '0, 1'b1, -1, 1'b0);
    do_fill(32'h0000_0000, '0, {NB{4'd1}}, '0, 1'b0, 1, 1'b0);
    do_fill(32'h0000_0010, {NB{4'd2}}, '0, '0, 1'b0, 1, 1'b1);
    do_fill(32'h0000_0038, '0, '0, '0, 1'b0, -1, 1'b0);
    chk("crit_line", bif.fill_data_o, 128'h1111_0003_1111_0002_1111_0001_1111_0000);
    do_fill(32'hFFFF_FFFD, {NB{4'd1}}, '0, 4'b1000, 1'b1, -1, 1'b0);

    // Randomized fills over a salted memory image.
    salt = $urandom | 32'h1;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NB; k++) begin
        gw[k] = 4'($urandom_range(0, 3));
        rw[k] = 4'($urandom_range(0, 3));
      end
      em = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      do_fill($urandom, gw, rw, em, 1'($urandom), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
